// File: rtl/param_data_memory.sv
// param_data_memory: DEPTH x DATA_W data store with one valid/ready write
// port, NUM_RD registered read ports, a post-reset clear sweep (one word
// per cycle, busy while sweeping) and optional write-to-read bypass.
module param_data_memory #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       ADDR_W    = 4,
   parameter int unsigned       NUM_RD    = 2,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
   parameter bit                BYPASS    = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   output logic                     busy
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                   state;
   logic [ADDR_W-1:0]        clr_ptr;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic [DATA_W-1:0]        rd_word [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] rd_data_q;
   logic [NUM_RD-1:0]        rd_valid_q;
   logic                     wr_fire;

   assign busy     = (state == ST_CLEAR);
   assign wr_ready = !busy;
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   // Sweep sequencer: reset (re)starts at word 0, leaves after the last word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
      end else if (state == ST_CLEAR) begin
         clr_ptr <= clr_ptr + ADDR_W'(1);
         if (&clr_ptr)
            state <= ST_READY;
      end
   end

   // Storage: sweep and accepted writes are mutually exclusive via busy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy)
            mem[clr_ptr] <= CLEAR_VAL;
         else if (wr_valid)
            mem[wr_addr] <= wr_data;
      end
   end

   // Per-port read word, with same-edge write forwarding when BYPASS is set.
   always_comb begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         rd_word[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
         if (BYPASS && wr_fire && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]))
            rd_word[i] = wr_data;
      end
   end

   // Registered read ports: data holds when idle, valid pulses per read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rd_en[i] && !busy) begin
               rd_valid_q[i]                 <= 1'b1;
               rd_data_q[i*DATA_W +: DATA_W] <= rd_word[i];
            end else begin
               rd_valid_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule
